// File: rtl/fetch_pkg.sv
// Shared definitions for the multicycle MIPS core: bus widths, reset/NOP
// defaults and the fetch-stage state encoding.
package cpu_defs;

  localparam int IF_ID_BUS_W = 64;
  localparam int JBR_BUS_W   = 33;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if_pc_next.sv
// Next-PC selection: a live taken branch wins, then a remembered redirect,
// otherwise the sequential pc+4 (32-bit modulo).
module if_pc_next
  import cpu_defs::*;
(
  input  logic [31:0]          pc_i,
  input  logic                 jbr_valid_i,
  input  logic [JBR_BUS_W-1:0] jbr_bus_i,
  input  logic                 redirect_pend_i,
  input  logic [31:0]          redirect_tgt_i,
  output logic [31:0]          next_pc_o
);

  logic [31:0] seqPc;

  assign seqPc = pc_i + 32'd4;

  always_comb begin
    next_pc_o = seqPc;
    if (jbr_valid_i) begin
      next_pc_o = jbr_bus_i[32] ? jbr_bus_i[31:0] : seqPc;
    end else if (redirect_pend_i) begin
      next_pc_o = redirect_tgt_i;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the architectural PC, performs one
// req/rvalid memory read per fetch and hands {pc, inst} to decode.
module fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IF_valid,
  input  logic                   next_fetch,
  input  logic                   jbr_valid,
  input  logic [JBR_BUS_W-1:0]   jbr_bus,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic [31:0]            inst_rdata,
  input  logic                   inst_rvalid,
  output logic                   IF_over,
  output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
  output logic [31:0]            IF_pc,
  output logic                   IF_addr_err
);

  fetch_state_e           state_q;
  logic [31:0]            pc_q;
  logic                   redirect_pend_q;
  logic [31:0]            redirect_tgt_q;
  logic                   inst_req_q;
  logic                   if_over_q;
  logic                   addr_err_q;
  logic [IF_ID_BUS_W-1:0] if_id_bus_q;
  logic [31:0]            pc_d;

  if_pc_next u_pc_next (
    .pc_i           (pc_q),
    .jbr_valid_i    (jbr_valid),
    .jbr_bus_i      (jbr_bus),
    .redirect_pend_i(redirect_pend_q),
    .redirect_tgt_i (redirect_tgt_q),
    .next_pc_o      (pc_d)
  );

  // Redirect capture runs in every state; a next_fetch consumes it, so its
  // clear is placed later and overrides a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      redirect_pend_q <= 1'b0;
      redirect_tgt_q  <= 32'd0;
      inst_req_q      <= 1'b0;
      if_over_q       <= 1'b0;
      addr_err_q      <= 1'b0;
      if_id_bus_q     <= '0;
    end else begin
      if (jbr_valid) begin
        redirect_pend_q <= jbr_bus[32];
        if (jbr_bus[32]) begin
          redirect_tgt_q <= jbr_bus[31:0];
        end
      end

      unique case (state_q)
        IDLE: begin
          if (next_fetch) begin
            pc_q            <= pc_d;
            redirect_pend_q <= 1'b0;
          end else if (IF_valid) begin
            if (pc_q[1:0] == 2'b00) begin
              state_q    <= WAIT;
              inst_req_q <= 1'b1;
            end else begin
              // Misaligned PC: skip memory and hand decode a NOP flagged as an error.
              state_q     <= DONE;
              if_id_bus_q <= {pc_q, NOP_INST};
              addr_err_q  <= 1'b1;
              if_over_q   <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (inst_rvalid) begin
            state_q     <= DONE;
            inst_req_q  <= 1'b0;
            if_id_bus_q <= {pc_q, inst_rdata};
            addr_err_q  <= 1'b0;
            if_over_q   <= 1'b1;
          end
        end

        DONE: begin
          state_q    <= IDLE;
          if_over_q  <= 1'b0;
          addr_err_q <= 1'b0;
          if (next_fetch) begin
            pc_q            <= pc_d;
            redirect_pend_q <= 1'b0;
          end
        end

        default: begin
          state_q    <= IDLE;
          inst_req_q <= 1'b0;
          if_over_q  <= 1'b0;
          addr_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign inst_req    = inst_req_q;
  assign inst_addr   = pc_q;
  assign IF_over     = if_over_q;
  assign IF_ID_bus   = if_id_bus_q;
  assign IF_pc       = pc_q;
  assign IF_addr_err = addr_err_q;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus pushes expected {err, pc, inst}
// entries, a negedge monitor pops and compares on every IF_over.
module tb_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_valid;
  logic        next_fetch;
  logic        jbr_valid;
  logic [32:0] jbr_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc;
  logic        IF_addr_err;

  int          checks = 0;
  int          errors = 0;
  logic [64:0] expQ[$];
  logic [64:0] expItem;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IF_valid   (IF_valid),
    .next_fetch (next_fetch),
    .jbr_valid  (jbr_valid),
    .jbr_bus    (jbr_bus),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_rvalid(inst_rvalid),
    .IF_over    (IF_over),
    .IF_ID_bus  (IF_ID_bus),
    .IF_pc      (IF_pc),
    .IF_addr_err(IF_addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of control inputs, then return them to idle.
  task automatic applyStimulus(input logic nf, input logic iv, input logic jv,
                               input logic [32:0] bus);
    next_fetch = nf;
    IF_valid   = iv;
    jbr_valid  = jv;
    jbr_bus    = bus;
    tick();
    next_fetch = 1'b0;
    IF_valid   = 1'b0;
    jbr_valid  = 1'b0;
    jbr_bus    = '0;
  endtask

  // Aligned fetch: memory answers 'delay' cycles after the first request.
  task automatic doFetch(input logic [31:0] data, input int delay,
                         input logic [31:0] expPc);
    applyStimulus(1'b0, 1'b1, 1'b0, 33'd0);
    checkOutput("inst_req_rise", 64'(inst_req), 64'd1);
    checkOutput("inst_addr", 64'(inst_addr), 64'(expPc));
    repeat (delay) tick();
    expQ.push_back({1'b0, expPc, data});
    inst_rdata  = data;
    inst_rvalid = 1'b1;
    tick();
    inst_rvalid = 1'b0;
    inst_rdata  = '0;
    checkOutput("if_over_timing", 64'(IF_over), 64'd1);
    checkOutput("inst_req_drop", 64'(inst_req), 64'd0);
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && IF_over) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_IF_over: got bus %h, expected no IF_over", IF_ID_bus);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("IF_ID_bus", IF_ID_bus, expItem[63:0]);
        checkOutput("IF_addr_err", 64'(IF_addr_err), 64'(expItem[64]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    IF_valid    = 1'b0;
    next_fetch  = 1'b0;
    jbr_valid   = 1'b0;
    jbr_bus     = '0;
    inst_rdata  = '0;
    inst_rvalid = 1'b0;
    tick();
    tick();
    checkOutput("reset_pc", 64'(IF_pc), 64'd0);
    checkOutput("reset_req", 64'(inst_req), 64'd0);
    checkOutput("reset_over", 64'(IF_over), 64'd0);
    checkOutput("reset_err", 64'(IF_addr_err), 64'd0);
    checkOutput("reset_bus", IF_ID_bus, 64'd0);
    rst = 1'b0;
    tick();

    // Minimum-latency fetch at the reset PC.
    doFetch(32'h2401_0005, 0, 32'h0000_0000);
    checkOutput("pc_hold_after_fetch", 64'(IF_pc), 64'd0);

    // Sequential advance to 0x10, fetch, then advance to 0x14.
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 33'd0);
    checkOutput("pc_seq_0x10", 64'(IF_pc), 64'h10);
    doFetch(32'h8C22_0004, 2, 32'h0000_0010);
    applyStimulus(1'b1, 1'b0, 1'b0, 33'd0);
    checkOutput("pc_seq_0x14", 64'(IF_pc), 64'h14);
    doFetch(32'h0022_1820, 1, 32'h0000_0014);

    // Pending redirect consumed two cycles later, then cleared.
    applyStimulus(1'b0, 1'b0, 1'b1, {1'b1, 32'h0000_0080});
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 33'd0);
    checkOutput("pc_pending_redirect", 64'(IF_pc), 64'h80);
    applyStimulus(1'b1, 1'b0, 1'b0, 33'd0);
    checkOutput("pc_redirect_cleared", 64'(IF_pc), 64'h84);

    // Live taken branch in the same cycle as next_fetch.
    applyStimulus(1'b1, 1'b0, 1'b1, {1'b1, 32'h0000_0200});
    checkOutput("pc_live_redirect", 64'(IF_pc), 64'h200);

    // A not-taken decode result cancels an earlier pending redirect.
    applyStimulus(1'b0, 1'b0, 1'b1, {1'b1, 32'h0000_0300});
    applyStimulus(1'b0, 1'b0, 1'b1, {1'b0, 32'h0000_0400});
    applyStimulus(1'b1, 1'b0, 1'b0, 33'd0);
    checkOutput("pc_not_taken_cancel", 64'(IF_pc), 64'h204);

    // Reset during a slow fetch; the late rvalid must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 33'd0);
    checkOutput("slow_req", 64'(inst_req), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_req", 64'(inst_req), 64'd0);
    checkOutput("midreset_pc", 64'(IF_pc), 64'd0);
    checkOutput("midreset_bus", IF_ID_bus, 64'd0);
    tick();
    inst_rdata  = 32'hDEAD_BEEF;
    inst_rvalid = 1'b1;
    tick();
    inst_rvalid = 1'b0;
    inst_rdata  = '0;
    tick();
    checkOutput("late_rvalid_bus", IF_ID_bus, 64'd0);
    checkOutput("late_rvalid_req", 64'(inst_req), 64'd0);

    // Misaligned PC: no memory request, NOP with error flag.
    applyStimulus(1'b1, 1'b0, 1'b1, {1'b1, 32'h0000_0102});
    checkOutput("pc_misaligned", 64'(IF_pc), 64'h102);
    expQ.push_back({1'b1, 32'h0000_0102, NOP});
    applyStimulus(1'b0, 1'b1, 1'b0, 33'd0);
    checkOutput("misaligned_no_req", 64'(inst_req), 64'd0);
    checkOutput("misaligned_over", 64'(IF_over), 64'd1);
    tick();
    checkOutput("misaligned_idle_req", 64'(inst_req), 64'd0);

    // pc+4 wraps at the top of the address space.
    applyStimulus(1'b1, 1'b0, 1'b1, {1'b1, 32'hFFFF_FFFC});
    checkOutput("pc_top", 64'(IF_pc), 64'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 33'd0);
    checkOutput("pc_wrap", 64'(IF_pc), 64'd0);

    // Aligned fetch after an error clears the flag.
    doFetch(32'h1234_5678, 3, 32'h0000_0000);

    tick();
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
